stream_serializer: RTL and testbench



---
 rtl/stream_serializer_if.sv | 33 +++
 rtl/stream_serializer.sv | 157 +++++++++++++++
 tb/tb_stream_serializer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_serializer_if.sv
// stream_serializer_if
// Bundles the word-in / beat-out handshake of the stream serializer.
//   in_data/in_len/in_valid/in_ready : word input handshake (source -> serializer)
//   out_data/out_last/out_valid/out_ready : beat output handshake (serializer -> sink)
//   busy : serializer holds an unfinished word
// Modports: master = the surrounding logic, slave = the serializer.
interface stream_serializer_if #(
    parameter int INWIDTH  = 256,
    parameter int OUTWIDTH = 8
);
    localparam int NWORDS = INWIDTH / OUTWIDTH;
    localparam int LW     = $clog2(NWORDS) + 1;

    logic [INWIDTH-1:0]  in_data;
    logic [LW-1:0]       in_len;
    logic                in_valid;
    logic                in_ready;
    logic [OUTWIDTH-1:0] out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_ready;
    logic                busy;

    modport master (
        output in_data, in_len, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_len, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/stream_serializer.sv
// stream_serializer
// Width-down serializer: takes one INWIDTH-bit word plus a beat count and emits
// it as OUTWIDTH-bit beats, LSB word first or MSB (highest valid word) first.
// A one-word holding buffer lets back-to-back words stream without a bubble.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : stream_serializer_if.slave (word input, beat output, busy)
module stream_serializer #(
    parameter int INWIDTH   = 256,
    parameter int OUTWIDTH  = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    stream_serializer_if.slave   bus
);
    localparam int NWORDS = INWIDTH / OUTWIDTH;
    localparam int LW     = $clog2(NWORDS) + 1;

    localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(NWORDS);

    // Lengths beyond the word size emit a full word.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len > LEN_MAX) begin
            return LEN_MAX;
        end else begin
            return len;
        end
    endfunction

    // In MSB-first mode the highest valid beat is moved to the top of the
    // shifter so the output always reads from the same fixed slice.
    function automatic logic [INWIDTH-1:0] align_word(input logic [INWIDTH-1:0] data,
                                                      input logic [LW-1:0]      len);
        if (MSB_FIRST) begin
            return data << (int'(LEN_MAX - len) * OUTWIDTH);
        end else begin
            return data;
        end
    endfunction

    logic [INWIDTH-1:0]  sr_r;
    logic [LW-1:0]       cnt_r;
    logic [INWIDTH-1:0]  hold_data_r;
    logic [LW-1:0]       hold_len_r;
    logic                hold_valid_r;

    logic [INWIDTH-1:0]  sr_next_s;
    logic [LW-1:0]       cnt_next_s;
    logic                hold_valid_next_s;
    logic [LW-1:0]       in_len_c_s;
    logic                in_xfer_s;
    logic                out_xfer_s;
    logic                in_nonzero_s;
    logic                free_s;
    logic                load_hold_s;
    logic                load_in_s;
    logic                to_hold_s;
    logic [OUTWIDTH-1:0] beat_s;

    // Handshake qualifiers and load arbitration.
    always_comb begin
        in_len_c_s   = clamp_len(bus.in_len);
        in_xfer_s    = bus.in_valid && bus.in_ready;
        out_xfer_s   = (cnt_r != LEN_ZERO) && bus.out_ready;
        in_nonzero_s = (bus.in_len != LEN_ZERO);
        free_s       = (cnt_r == LEN_ZERO) || ((cnt_r == LEN_ONE) && out_xfer_s);
        load_hold_s  = free_s && hold_valid_r;
        // in_ready implies an empty hold buffer, so this cannot collide with load_hold_s.
        load_in_s    = free_s && !hold_valid_r && in_xfer_s && in_nonzero_s;
        // Zero-length words are swallowed here and never reach the hold buffer.
        to_hold_s    = in_xfer_s && in_nonzero_s && !free_s;
    end

    // Next shifter contents and beat count.
    always_comb begin
        sr_next_s  = sr_r;
        cnt_next_s = cnt_r;
        if (load_hold_s) begin
            sr_next_s  = align_word(hold_data_r, hold_len_r);
            cnt_next_s = hold_len_r;
        end else if (load_in_s) begin
            sr_next_s  = align_word(bus.in_data, in_len_c_s);
            cnt_next_s = in_len_c_s;
        end else if (out_xfer_s) begin
            if (MSB_FIRST) begin
                sr_next_s = sr_r << OUTWIDTH;
            end else begin
                sr_next_s = sr_r >> OUTWIDTH;
            end
            cnt_next_s = cnt_r - LEN_ONE;
        end else begin
            sr_next_s  = sr_r;
            cnt_next_s = cnt_r;
        end
    end

    // Next hold-buffer occupancy.
    always_comb begin
        hold_valid_next_s = hold_valid_r;
        if (load_hold_s) begin
            hold_valid_next_s = 1'b0;
        end else if (to_hold_s) begin
            hold_valid_next_s = 1'b1;
        end else begin
            hold_valid_next_s = hold_valid_r;
        end
    end

    // Shifter, counter and hold-buffer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r         <= {INWIDTH{1'b0}};
            cnt_r        <= LEN_ZERO;
            hold_data_r  <= {INWIDTH{1'b0}};
            hold_len_r   <= LEN_ZERO;
            hold_valid_r <= 1'b0;
        end else begin
            sr_r         <= sr_next_s;
            cnt_r        <= cnt_next_s;
            hold_valid_r <= hold_valid_next_s;
            if (to_hold_s) begin
                hold_data_r <= bus.in_data;
                hold_len_r  <= in_len_c_s;
            end else begin
                hold_data_r <= hold_data_r;
                hold_len_r  <= hold_len_r;
            end
        end
    end

    // Output beat slice; forced to zero when no beat is pending since the
    // shifter may still hold leftovers of a partly used word.
    always_comb begin
        if (MSB_FIRST) begin
            beat_s = sr_r[INWIDTH-1 -: OUTWIDTH];
        end else begin
            beat_s = sr_r[OUTWIDTH-1:0];
        end
    end

    // Outputs derive only from state (plus reset for in_ready), never from out_ready/in_valid.
    always_comb begin
        bus.out_valid = (cnt_r != LEN_ZERO);
        bus.out_last  = (cnt_r == LEN_ONE);
        bus.busy      = (cnt_r != LEN_ZERO) || hold_valid_r;
        bus.in_ready  = !reset && !hold_valid_r;
        if (cnt_r != LEN_ZERO) begin
            bus.out_data = beat_s;
        end else begin
            bus.out_data = {OUTWIDTH{1'b0}};
        end
    end
endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer
// Directed bench: two 32->8 serializers (LSB-first and MSB-first) on a shared
// clock and reset, driven through stream_serializer_if instances.
module tb_stream_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stream_serializer_if #(.INWIDTH(32), .OUTWIDTH(8)) bus_a ();
    stream_serializer_if #(.INWIDTH(32), .OUTWIDTH(8)) bus_b ();

    stream_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    stream_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    logic [31:0] w_data [4];
    logic [2:0]  w_len  [4];
    logic [7:0]  exp_beat [16];
    logic        exp_last [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams nw words from w_data/w_len on bus_a and checks nbeats beats
    // against exp_beat/exp_last. bp selects the 1-0-0-1 out_ready pattern.
    task automatic run_stream(input int nw, input int nbeats, input bit bp, input string tag);
        int wi = 0;
        int bi = 0;
        int cyc = 0;
        int gaps = 0;
        bit started = 1'b0;
        bit saw_block = 1'b0;
        bit stall_prev = 1'b0;
        bit acc;
        logic [7:0] prev_d = 8'h00;
        logic prev_l = 1'b0;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus_a.in_data   = w_data[0];
        bus_a.in_len    = w_len[0];
        bus_a.in_valid  = 1'b1;
        bus_a.out_ready = 1'b1;
        while (bi < nbeats && cyc < 200) begin
            if (stall_prev) begin
                check_eq({tag, "_stall_valid"}, {31'd0, bus_a.out_valid}, 32'd1);
                check_eq({tag, "_stall_data"}, {24'd0, bus_a.out_data}, {24'd0, prev_d});
                check_eq({tag, "_stall_last"}, {31'd0, bus_a.out_last}, {31'd0, prev_l});
            end
            if (bus_a.out_valid) started = 1'b1;
            if (started && !bus_a.out_valid) gaps++;
            if (bus_a.in_valid && !bus_a.in_ready) saw_block = 1'b1;
            acc = bus_a.in_valid && bus_a.in_ready;
            if (bus_a.out_valid && bus_a.out_ready) begin
                check_eq({tag, "_beat"}, {24'd0, bus_a.out_data}, {24'd0, exp_beat[bi]});
                check_eq({tag, "_last"}, {31'd0, bus_a.out_last}, {31'd0, exp_last[bi]});
                bi++;
            end
            stall_prev = bus_a.out_valid && !bus_a.out_ready;
            prev_d = bus_a.out_data;
            prev_l = bus_a.out_last;
            tick();
            cyc++;
            if (acc) begin
                wi++;
                if (wi < nw) begin
                    bus_a.in_data = w_data[wi];
                    bus_a.in_len  = w_len[wi];
                end else begin
                    bus_a.in_valid = 1'b0;
                end
            end
            bus_a.out_ready = bp ? pat[cyc % 4] : 1'b1;
        end
        check_eq({tag, "_beat_count"}, bi, nbeats);
        if (!bp) check_eq({tag, "_gaps"}, gaps, 32'd0);
        if (nw > 1 && !bp) check_eq({tag, "_in_ready_drop"}, {31'd0, saw_block}, 32'd1);
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        tick();
        check_eq({tag, "_idle_after"}, {31'd0, bus_a.out_valid}, 32'd0);
        check_eq({tag, "_busy_after"}, {31'd0, bus_a.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] t1_exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [7:0] t2_exp [3] = '{8'hCC, 8'hBB, 8'hAA};
        logic [7:0] t6_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        bus_a.in_data = 32'd0; bus_a.in_len = 3'd0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_data = 32'd0; bus_b.in_len = 3'd0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        tick();
        tick();
        // reset state
        check_eq("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
        check_eq("rst_out_last", {31'd0, bus_a.out_last}, 32'd0);
        check_eq("rst_out_data", {24'd0, bus_a.out_data}, 32'd0);
        check_eq("rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check_eq("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);

        // LSB-first single word, latency and order
        bus_a.in_data = 32'hDDCCBBAA; bus_a.in_len = 3'd4; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_valid", {31'd0, bus_a.out_valid}, 32'd1);
            check_eq("t1_data", {24'd0, bus_a.out_data}, {24'd0, t1_exp[i]});
            check_eq("t1_last", {31'd0, bus_a.out_last}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("t1_done_valid", {31'd0, bus_a.out_valid}, 32'd0);
        check_eq("t1_done_busy", {31'd0, bus_a.busy}, 32'd0);

        // MSB-first, len 3, then len 0
        bus_b.in_data = 32'h00CCBBAA; bus_b.in_len = 3'd3; bus_b.in_valid = 1'b1;
        tick();
        bus_b.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_valid", {31'd0, bus_b.out_valid}, 32'd1);
            check_eq("t2_data", {24'd0, bus_b.out_data}, {24'd0, t2_exp[i]});
            check_eq("t2_last", {31'd0, bus_b.out_last}, (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("t2_done_valid", {31'd0, bus_b.out_valid}, 32'd0);
        bus_b.in_data = 32'h55667788; bus_b.in_len = 3'd0; bus_b.in_valid = 1'b1;
        check_eq("t2_len0_ready", {31'd0, bus_b.in_ready}, 32'd1);
        tick();
        bus_b.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_len0_valid", {31'd0, bus_b.out_valid}, 32'd0);
            check_eq("t2_len0_busy", {31'd0, bus_b.busy}, 32'd0);
            check_eq("t2_len0_in_ready", {31'd0, bus_b.in_ready}, 32'd1);
            tick();
        end

        // three back-to-back words, 12 contiguous beats
        w_data[0] = 32'h04030201; w_data[1] = 32'h08070605; w_data[2] = 32'h0C0B0A09;
        w_len[0] = 3'd4; w_len[1] = 3'd4; w_len[2] = 3'd4;
        for (int i = 0; i < 12; i++) begin
            exp_beat[i] = 8'(i + 1);
            exp_last[i] = ((i % 4) == 3);
        end
        run_stream(3, 12, 1'b0, "t3");

        // backpressure 1-0-0-1
        run_stream(2, 8, 1'b1, "t4");

        // length clamp: 7 -> 4 beats
        w_data[0] = 32'hDDCCBBAA; w_len[0] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            exp_beat[i] = t1_exp[i];
            exp_last[i] = (i == 3);
        end
        run_stream(1, 4, 1'b0, "t5");

        // accept coinciding with last-beat transfer, empty hold buffer
        bus_a.in_data = 32'h0D0C0B0A; bus_a.in_len = 3'd7; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("t5b_last_pending", {31'd0, bus_a.out_last}, 32'd1);
        check_eq("t5b_last_data", {24'd0, bus_a.out_data}, 32'h0D);
        bus_a.in_data = 32'h14131211; bus_a.in_len = 3'd4; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        check_eq("t5b_direct_valid", {31'd0, bus_a.out_valid}, 32'd1);
        check_eq("t5b_direct_data", {24'd0, bus_a.out_data}, 32'h11);
        check_eq("t5b_hold_empty", {31'd0, bus_a.in_ready}, 32'd1);
        tick(); tick(); tick();
        check_eq("t5b_tail_data", {24'd0, bus_a.out_data}, 32'h14);
        check_eq("t5b_tail_last", {31'd0, bus_a.out_last}, 32'd1);
        tick();

        // reset mid-word
        bus_a.in_data = 32'hDDCCBBAA; bus_a.in_len = 3'd4; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        tick(); tick();
        check_eq("t6_pre_data", {24'd0, bus_a.out_data}, 32'hCC);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_valid", {31'd0, bus_a.out_valid}, 32'd0);
        check_eq("t6_rst_data", {24'd0, bus_a.out_data}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check_eq("t6_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("t6_rel_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        check_eq("t6_rel_valid", {31'd0, bus_a.out_valid}, 32'd0);
        bus_a.in_data = 32'h11223344; bus_a.in_len = 3'd4; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t6_valid", {31'd0, bus_a.out_valid}, 32'd1);
            check_eq("t6_data", {24'd0, bus_a.out_data}, {24'd0, t6_exp[i]});
            check_eq("t6_last", {31'd0, bus_a.out_last}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("t6_done_valid", {31'd0, bus_a.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
